mux_scan_seq: RTL and testbench
===============================

// Module: mux_scan_seq
// PURPOSE
//   Scan sequencer paired with the 4:1 bit mux. Drives the mux select through the
//   enabled channels, waits a settle time on each, and samples the 1-bit mux output.
//   Packs the samples into a parallel word and reports completion with a done pulse.
//   Sits upstream of the mux on sel and downstream of it on out: a closed scan loop.
// PARAMETERS
//   N_CH   4              number of mux channels (data_in width of the mux)
//   SEL_W  $clog2(N_CH)   select width; 2 for the 4:1 mux
//   DWELL  2              cycles sel is held per channel before sampling; legal >= 1
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous, active-high reset
//   start        in   1      scan request; accepted only in IDLE
//   ch_mask      in   N_CH   channels to scan; latched on accepted start
//   sel          out  SEL_W  mux select (registered)
//   mux_out      in   1      mux output bit
//   busy         out  1      scan in progress
//   done         out  1      one-cycle pulse: sample_word valid
//   sample_word  out  N_CH   captured bits; bit i = mux_out sampled with sel==i
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE, sel=0, busy=0, done=0,
//     sample_word=0, dwell counter=0. Reset mid-scan aborts; no done pulse.
//   - States: IDLE -> SETTLE -> DONE -> IDLE.
//   - IDLE: busy=0, sel holds last value. On start=1 at edge E0: latch ch_mask,
//     clear sample_word to 0, cnt=0. Mask!=0: sel=lowest set index, busy=1,
//     go SETTLE. Mask==0: go DONE directly (busy never asserts).
//   - SETTLE: sel stable, cnt increments each edge. At the edge where
//     cnt==DWELL-1: sample_word[sel] <= mux_out. If a higher masked channel
//     exists: sel <= next higher set index, cnt <= 0, stay. Else go DONE, busy <= 0.
//   - DONE: done=1 for exactly one cycle, busy=0; next edge -> IDLE, done=0.
//   - Latency: k enabled channels -> done high in the cycle beginning at edge
//     E0 + k*DWELL. Mask==0 gives done in the cycle after E0.
//   - Unscanned bits of sample_word read 0. sample_word holds until next accepted start.
//   - start while busy or in DONE is ignored. The ch_mask change mid-scan has no
//     effect. A mux_out change outside the sampling edge has no effect.
//   - Channels scan in ascending index order; no wrap-around within one scan.
//   - No combinational path from any input to any output.
// TESTING  (bench models the 4:1 mux: mux_out = data_in[sel]; DWELL=2)
//   1. Assert rst for 2 cycles mid-activity -> sel=0, busy=0, done=0, sample_word=0.
//   2. data_in=4'b1010, ch_mask=4'b1111, start 1 cycle -> sel 0,0,1,1,2,2,3,3;
//      done at E0+8; sample_word=4'b1010; busy high for exactly 8 cycles.
//   3. data_in=4'b1111, ch_mask=4'b0101 -> sel 0,0,2,2; done at E0+4;
//      sample_word=4'b0101.
//   4. ch_mask=4'b0000, start -> done pulse in the cycle after E0; sample_word=0;
//      busy stays 0.
//   5. Hold start high through a full-mask scan -> exactly one done per scan.
//      The DONE cycle does not restart. A new scan begins on the first IDLE cycle.
//   6. Scan with ch_mask=4'b1111, assert rst at E0+3 -> no done pulse;
//      all outputs reset. The next start completes normally.

Source files
------------

// File: rtl/mux_scan_seq.sv
// Scan sequencer for a 4:1 bit mux: steps sel through the masked channels, waits
// DWELL cycles on each, samples mux_out and reports the packed word with a done pulse.
module mux_scan_seq #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH),
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_CH-1:0]  ch_mask,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_out,
  output logic             busy,
  output logic             done,
  output logic [N_CH-1:0]  sample_word,
  output logic [1:0]       fsm_state
);

  // Handshake: start is a level request taken only in IDLE (ignored while busy or
  // in DONE); done is a one-cycle pulse and sample_word stays valid until the next
  // accepted start. There is no backpressure on the result.

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [N_CH-1:0]   mask, mask_nxt, word_nxt;
  logic [SEL_W-1:0]  sel_nxt, low_idx, next_idx;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              busy_nxt, done_nxt, has_next, last_dwell;

  assign fsm_state  = state;
  assign last_dwell = (cnt == CNT_W'(DWELL - 1));

  // Channel search: lowest set bit of the incoming mask, next higher set bit of
  // the latched mask above the current select.
  always_comb begin
    low_idx  = '0;
    next_idx = sel;
    has_next = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) low_idx = SEL_W'(i);
      if (mask[i] && (i > int'(sel))) begin
        next_idx = SEL_W'(i);
        has_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mask        <= '0;
      sel         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sample_word <= '0;
    end else begin
      state       <= state_nxt;
      mask        <= mask_nxt;
      sel         <= sel_nxt;
      cnt         <= cnt_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      sample_word <= word_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (ch_mask != '0) ? SETTLE : DONE;
      SETTLE:  if (last_dwell && !has_next) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; done is raised on the same edge that
  // enters DONE so it lines up with the state.
  always_comb begin
    mask_nxt = mask;
    sel_nxt  = sel;
    cnt_nxt  = cnt;
    busy_nxt = busy;
    done_nxt = 1'b0;
    word_nxt = sample_word;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          mask_nxt = ch_mask;
          word_nxt = '0;
          cnt_nxt  = '0;
          if (ch_mask != '0) begin
            sel_nxt  = low_idx;
            busy_nxt = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (last_dwell) begin
          word_nxt[sel] = mux_out;
          cnt_nxt       = '0;
          if (has_next) begin
            sel_nxt = next_idx;
          end else begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE:    busy_nxt = 1'b0;
      default: busy_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq with a behavioural 4:1 mux closing the loop (DWELL=2).
module tb_mux_scan_seq;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int DWELL = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [N_CH-1:0]  ch_mask;
  logic [SEL_W-1:0] sel;
  logic             mux_out;
  logic             busy;
  logic             done;
  logic [N_CH-1:0]  sample_word;
  logic [1:0]       fsm_state;
  logic [N_CH-1:0]  data_in;

  int errors = 0;
  int checks = 0;
  logic [N_CH-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign mux_out = data_in[sel];

  mux_scan_seq #(.N_CH(N_CH), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ch_mask     (ch_mask),
    .sel         (sel),
    .mux_out     (mux_out),
    .busy        (busy),
    .done        (done),
    .sample_word (sample_word),
    .fsm_state   (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sel"},   32'(sel), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_word"},  32'(sample_word), 0);
    check({tag, "_state"}, 32'(fsm_state), 0);
  endtask

  task automatic apply_reset(input string tag, input int cyc);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    repeat (cyc) @(negedge clk);
    check_idle_outputs(tag);
    rst = 1'b0;
  endtask

  // Start a full-mask scan, raise rst so it is sampled at edge E0+after+1,
  // then confirm outputs are cleared and no done pulse ever appears.
  task automatic abort_scan(input string tag, input int after);
    int dones;
    @(negedge clk);
    data_in = 4'b1111;
    ch_mask = 4'b1111;
    start   = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= after; n++) begin
      @(negedge clk);
      start = 1'b0;
      check({tag, "_pre_done"}, 32'(done), 0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs(tag);
    rst   = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check({tag, "_no_done"}, 32'(dones), 0);
  endtask

  // One scan with scoreboard: expected word queued at start, popped on done.
  task automatic run_scan(input logic [N_CH-1:0] m, input logic [N_CH-1:0] d, input bit noisy);
    int k, lat, busy_cnt;
    bit seen;
    logic [SEL_W-1:0] sel_q[$];
    @(negedge clk);
    data_in = d;
    ch_mask = m;
    start   = 1'b1;
    k = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (m[i]) begin
        k++;
        for (int j = 0; j < DWELL; j++) sel_q.push_back(SEL_W'(i));
      end
    end
    exp_q.push_back(d & m);
    lat = k * DWELL;
    @(posedge clk);
    seen     = 1'b0;
    busy_cnt = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      start   = (noisy && n < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      ch_mask = noisy ? N_CH'($urandom_range(0, 15)) : m;
      if (busy) begin
        busy_cnt++;
        if (sel_q.size() > 0) check("sel_seq", 32'(sel), 32'(sel_q.pop_front()));
        else check("sel_extra_busy", 32'(busy), 0);
      end
      if (done) begin
        seen = 1'b1;
        check("done_latency", n, lat);
        check("busy_in_done", 32'(busy), 0);
        if (exp_q.size() > 0) check("sample_word", 32'(sample_word), 32'(exp_q.pop_front()));
      end
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 1);
    check("busy_cycles", busy_cnt, lat);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    if (seen) check("word_hold", 32'(sample_word), 32'(d & m));
  endtask

  // start held high: done every k*DWELL+2 cycles, DONE cycle never restarts.
  task automatic held_start();
    int dones;
    logic [N_CH-1:0] d;
    d = 4'b0110;
    @(negedge clk);
    data_in = d;
    ch_mask = 4'b1111;
    start   = 1'b1;
    @(posedge clk);
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) begin
        check("held_done_idx", n, 8 + 10 * dones);
        check("held_word", 32'(sample_word), 32'(d));
        dones++;
      end
      if (n == 9)  check("held_idle_busy", 32'(busy), 0);
      if (n == 10) check("held_restart_busy", 32'(busy), 1);
    end
    start = 1'b0;
    check("held_done_count", dones, 3);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    ch_mask = '0;
    data_in = '0;
    apply_reset("por", 2);

    abort_scan("mid_rst", 4);
    run_scan(4'b1111, 4'b1010, 1'b0);
    run_scan(4'b0101, 4'b1111, 1'b0);
    run_scan(4'b0000, 4'b1111, 1'b0);
    held_start();
    abort_scan("rst_e3", 2);
    run_scan(4'b1111, 4'b0011, 1'b0);
    run_scan(4'b1000, 4'b1000, 1'b1);
    run_scan(4'b0001, 4'b1110, 1'b0);

    for (int t = 0; t < 8; t++) begin
      run_scan(N_CH'($urandom_range(0, 15)), N_CH'($urandom_range(0, 15)), 1'b1);
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
